sipo_rx_ctrl: RTL and testbench
===============================

# sipo_rx_ctrl

Controller that sequences a WIDTH-bit serial-in/parallel-out shift register into a framed word receiver. It waits for a frame start, gates shifting with a per-bit strobe, counts bits, and transfers each completed word into an output holding register. The output register is offered downstream on a valid/ready handshake. It sits between a serial bit source (pin sampler, bit-bang link) and any parallel consumer, and reports dropped words via a sticky overrun flag.

## Interface
- WIDTH, 4: word length in bits, ≥2.
- clk  in  1  rising-edge clock.
- rstn  in  1  reset, asynchronous, active-low.
- start  in  1  frame-start pulse; one cycle.
- sin  in  1  serial data bit.
- sin_valid  in  1  strobe: sample sin this cycle.
- dout  out  WIDTH  received word; first-received bit in dout[0].
- dout_valid  out  1  dout holds an unconsumed word.
- dout_ready  in  1  consumer accepts dout when dout_valid && dout_ready.
- busy  out  1  frame in progress (state SHIFT).
- overrun  out  1  sticky: a completed word was dropped.
- ovr_clr  in  1  clears overrun.

## Operation
- Reset (rstn=0, asynchronous): state IDLE, shift register 0, bit count 0, dout 0, dout_valid 0, busy 0, overrun 0.
- FSM, two states:
  - IDLE: sin_valid ignored. start → SHIFT, count←0, shift register←0.
  - SHIFT: each sin_valid cycle shifts: sr←{sin, sr[WIDTH-1:1]}, count+1. The new bit enters the MSB, so after WIDTH shifts the first bit sits in sr[0].
  - On the shift that makes count==WIDTH, the word is complete: state→IDLE, count←0.
  - start while in SHIFT restarts the frame: count←0, sr←0, stay SHIFT. Partial bits are discarded and no word is produced. start takes priority over a same-cycle sin_valid.
- The start cycle never samples data. The first data bit is the first sin_valid after the start cycle.
- Word transfer on completion, evaluated in the completion cycle:
  - Output register empty (dout_valid=0), or accepted this cycle (dout_valid && dout_ready): dout←{sin, sr[WIDTH-1:1]}, dout_valid←1.
  - Otherwise the new word is dropped, dout is unchanged, overrun←1.
- Handshake: dout and dout_valid hold stable while dout_valid && !dout_ready. Acceptance with no completion in the same cycle clears dout_valid. dout keeps its last value after acceptance.
- overrun: set as above. Cleared by ovr_clr. If set and ovr_clr occur in the same cycle, set wins.
- Count width: $clog2(WIDTH+1) bits. Count never exceeds WIDTH and never wraps.

## Timing
- dout_valid rises on the clock edge that samples the WIDTH-th bit, i.e. one cycle after that bit is presented. No additional latency.
- busy rises on the edge after start and falls on the edge that samples the last bit.
- Back-to-back frames: a start may arrive in the cycle immediately after completion. Minimum frame period is 1 + WIDTH cycles.
- Throughput: one word per frame with no stall, provided the consumer accepts within WIDTH+1 cycles.
- All outputs are registered. No combinational path from inputs to outputs.

## Structure
- Package sipo_rx_pkg: state enum (ST_IDLE, ST_SHIFT) and a count-width function/constant derived from WIDTH.
- Sub-module sipo_shift_en: parameterized WIDTH shift register with shift enable and synchronous clear, on the same asynchronous active-low reset. The controller instantiates it and owns the FSM, count, output register and flags.

## Test plan
- WIDTH=4: start, then sin_valid with bits 1,0,1,1 on consecutive cycles → dout=4'hD, dout_valid=1 on the edge sampling the 4th bit; busy 1 for exactly 4 cycles.
- Gaps: the same bits with sin_valid idle for 3 cycles between bits → same dout=4'hD; count holds during gaps.
- Overrun: dout_ready=0, two full frames (4'hD, then 4'h2) → dout stays 4'hD, overrun=1. ovr_clr → overrun=0.
- Simultaneous completion and acceptance: dout_valid=1 with dout_ready=1 in the completion cycle of the second word → dout updates to the new word, dout_valid stays 1, overrun stays 0.
- Restart: start, bits 1,1, start again, bits 0,0,0,1 → single word 4'h8; no word produced for the aborted frame.
- Reset mid-frame: rstn low after 2 bits → all outputs 0 immediately (asynchronous). After release, sin_valid without start produces no word.

Source files
------------

// File: rtl/sipo_rx_pkg.sv
// Shared types and sizing helpers for the framed serial-in/parallel-out receiver.
package sipo_rx_pkg;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    // Bit-count width that can hold the values 0..w inclusive.
    function automatic int unsigned cnt_width(input int unsigned w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/sipo_shift_en.sv
// WIDTH-bit right-shifting register: new bits enter the MSB when enabled.
// The synchronous clear takes priority over the shift enable.
module sipo_shift_en #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             clr,
    input  logic             en,
    input  logic             din,
    output logic [WIDTH-1:0] sr
);

    logic [WIDTH-1:0] sr_r;

    // Shift register state with clear-over-shift priority.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sr_r <= '0;
        end else if (clr) begin
            sr_r <= '0;
        end else if (en) begin
            sr_r <= {din, sr_r[WIDTH-1:1]};
        end else begin
            sr_r <= sr_r;
        end
    end

    assign sr = sr_r;

endmodule

// File: rtl/sipo_rx_ctrl.sv
// Framed serial word receiver: start-triggered bit counting, word capture into a
// valid/ready output register, and a sticky overrun flag for dropped words.
module sipo_rx_ctrl
    import sipo_rx_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic             sin,
    input  logic             sin_valid,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             busy,
    output logic             overrun,
    input  logic             ovr_clr
);

    localparam int unsigned CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    state_t           state_r, state_nxt_s;
    logic [CW-1:0]    cnt_r, cnt_nxt_s;
    logic [WIDTH-1:0] sr_s, word_s, dout_r;
    logic             sr_clr_s, sr_en_s, complete_s;
    logic             load_s, accept_s, drop_s;
    logic             dout_valid_r, busy_r, overrun_r;
    logic             unused_s;

    sipo_shift_en #(.WIDTH(WIDTH)) u_shift (
        .clk  (clk),
        .rstn (rstn),
        .clr  (sr_clr_s),
        .en   (sr_en_s),
        .din  (sin),
        .sr   (sr_s)
    );

    // The completing shift is captured straight into dout, so sr[0] is never read.
    assign word_s   = {sin, sr_s[WIDTH-1:1]};
    assign unused_s = sr_s[0];

    // Next state, bit count and shift-register controls; start outranks sin_valid.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        sr_clr_s    = 1'b0;
        sr_en_s     = 1'b0;
        complete_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_nxt_s = ST_SHIFT;
                    cnt_nxt_s   = '0;
                    sr_clr_s    = 1'b1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (start) begin
                    state_nxt_s = ST_SHIFT;
                    cnt_nxt_s   = '0;
                    sr_clr_s    = 1'b1;
                end else if (sin_valid) begin
                    sr_en_s = 1'b1;
                    if (cnt_r == LAST_CNT) begin
                        complete_s  = 1'b1;
                        state_nxt_s = ST_IDLE;
                        cnt_nxt_s   = '0;
                    end else begin
                        cnt_nxt_s = cnt_r + CNT_ONE;
                    end
                end else begin
                    cnt_nxt_s = cnt_r;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = '0;
            end
        endcase
    end

    assign accept_s = dout_valid_r & dout_ready;
    assign load_s   = complete_s & (~dout_valid_r | dout_ready);
    assign drop_s   = complete_s & dout_valid_r & ~dout_ready;

    // FSM state, bit count and registered busy.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r <= ST_IDLE;
            cnt_r   <= '0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            busy_r  <= (state_nxt_s == ST_SHIFT);
        end
    end

    // Output holding register and handshake; a completion while full drops the word.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            dout_r       <= '0;
            dout_valid_r <= 1'b0;
        end else if (load_s) begin
            dout_r       <= word_s;
            dout_valid_r <= 1'b1;
        end else if (accept_s) begin
            dout_r       <= dout_r;
            dout_valid_r <= 1'b0;
        end else begin
            dout_r       <= dout_r;
            dout_valid_r <= dout_valid_r;
        end
    end

    // Sticky overrun; a same-cycle drop beats the clear.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            overrun_r <= 1'b0;
        end else if (drop_s) begin
            overrun_r <= 1'b1;
        end else if (ovr_clr) begin
            overrun_r <= 1'b0;
        end else begin
            overrun_r <= overrun_r;
        end
    end

    assign dout       = dout_r;
    assign dout_valid = dout_valid_r;
    assign busy       = busy_r;
    assign overrun    = overrun_r;

endmodule

// File: tb/tb_sipo_rx_ctrl.sv
// Directed self-checking bench for sipo_rx_ctrl at WIDTH=4.
`timescale 1ns/1ps
module tb_sipo_rx_ctrl;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       start = 1'b0;
    logic       sin = 1'b0;
    logic       sin_valid = 1'b0;
    logic [3:0] dout;
    logic       dout_valid;
    logic       dout_ready = 1'b0;
    logic       busy;
    logic       overrun;
    logic       ovr_clr = 1'b0;

    int checks = 0;
    int failures = 0;

    sipo_rx_ctrl #(.WIDTH(4)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .start      (start),
        .sin        (sin),
        .sin_valid  (sin_valid),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .busy       (busy),
        .overrun    (overrun),
        .ovr_clr    (ovr_clr)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start pulse followed by four consecutive bits, LSB (first bit) first.
    task automatic send_word(input logic [3:0] w);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            sin = w[i];
            sin_valid = 1'b1;
            tick();
        end
        sin_valid = 1'b0;
        sin = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        #12;
        checks++; if (dout !== 4'h0)      begin failures++; $display("FAIL reset_dout got=%h exp=0", dout); end
        checks++; if (dout_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", dout_valid); end
        checks++; if (busy !== 1'b0)       begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (overrun !== 1'b0)    begin failures++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
        @(negedge clk);
        rstn = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        logic [3:0] w;
        int nbusy;
        w = 4'hD;
        nbusy = 0;
        dout_ready = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        if (busy === 1'b1) nbusy++;
        for (int i = 0; i < 4; i++) begin
            sin = w[i];
            sin_valid = 1'b1;
            tick();
            if (i < 3) begin
                checks++; if (dout_valid !== 1'b0) begin failures++; $display("FAIL basic_early_valid bit=%0d got=%b exp=0", i, dout_valid); end
            end
            if (busy === 1'b1) nbusy++;
        end
        sin_valid = 1'b0;
        checks++; if (dout !== 4'hD)       begin failures++; $display("FAIL basic_dout got=%h exp=d", dout); end
        checks++; if (dout_valid !== 1'b1) begin failures++; $display("FAIL basic_valid got=%b exp=1", dout_valid); end
        checks++; if (busy !== 1'b0)       begin failures++; $display("FAIL basic_busy_fall got=%b exp=0", busy); end
        checks++; if (nbusy != 4)          begin failures++; $display("FAIL basic_busy_cycles got=%0d exp=4", nbusy); end
        tick();
        checks++; if (dout_valid !== 1'b1) begin failures++; $display("FAIL basic_hold_valid got=%b exp=1", dout_valid); end
        dout_ready = 1'b1;
        tick();
        dout_ready = 1'b0;
        checks++; if (dout_valid !== 1'b0) begin failures++; $display("FAIL basic_accept_valid got=%b exp=0", dout_valid); end
        checks++; if (dout !== 4'hD)       begin failures++; $display("FAIL basic_dout_kept got=%h exp=d", dout); end
    endtask

    task automatic test_gaps();
        logic [3:0] w;
        w = 4'hD;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            repeat (3) begin
                sin = ~w[i];
                sin_valid = 1'b0;
                tick();
            end
            sin = w[i];
            sin_valid = 1'b1;
            tick();
            sin_valid = 1'b0;
            if (i < 3) begin
                checks++; if (dout_valid !== 1'b0) begin failures++; $display("FAIL gaps_early_valid bit=%0d got=%b exp=0", i, dout_valid); end
                checks++; if (busy !== 1'b1)       begin failures++; $display("FAIL gaps_busy bit=%0d got=%b exp=1", i, busy); end
            end
        end
        checks++; if (dout !== 4'hD)       begin failures++; $display("FAIL gaps_dout got=%h exp=d", dout); end
        checks++; if (dout_valid !== 1'b1) begin failures++; $display("FAIL gaps_valid got=%b exp=1", dout_valid); end
        dout_ready = 1'b1;
        tick();
        dout_ready = 1'b0;
    endtask

    task automatic test_overrun();
        dout_ready = 1'b0;
        send_word(4'hD);
        checks++; if (dout_valid !== 1'b1) begin failures++; $display("FAIL ovr_first_valid got=%b exp=1", dout_valid); end
        checks++; if (overrun !== 1'b0)    begin failures++; $display("FAIL ovr_first_flag got=%b exp=0", overrun); end
        send_word(4'h2);
        checks++; if (dout !== 4'hD)       begin failures++; $display("FAIL ovr_dout_kept got=%h exp=d", dout); end
        checks++; if (dout_valid !== 1'b1) begin failures++; $display("FAIL ovr_valid got=%b exp=1", dout_valid); end
        checks++; if (overrun !== 1'b1)    begin failures++; $display("FAIL ovr_set got=%b exp=1", overrun); end
        ovr_clr = 1'b1;
        tick();
        ovr_clr = 1'b0;
        checks++; if (overrun !== 1'b0)    begin failures++; $display("FAIL ovr_clear got=%b exp=0", overrun); end
        ovr_clr = 1'b1;
        send_word(4'h5);
        ovr_clr = 1'b0;
        checks++; if (overrun !== 1'b1)    begin failures++; $display("FAIL ovr_set_wins got=%b exp=1", overrun); end
        checks++; if (dout !== 4'hD)       begin failures++; $display("FAIL ovr_dout_kept2 got=%h exp=d", dout); end
        ovr_clr = 1'b1;
        dout_ready = 1'b1;
        tick();
        ovr_clr = 1'b0;
        dout_ready = 1'b0;
        checks++; if (overrun !== 1'b0)    begin failures++; $display("FAIL ovr_clear2 got=%b exp=0", overrun); end
        checks++; if (dout_valid !== 1'b0) begin failures++; $display("FAIL ovr_accept got=%b exp=0", dout_valid); end
    endtask

    task automatic test_simul_accept();
        logic [3:0] w;
        w = 4'h2;
        dout_ready = 1'b0;
        send_word(4'hD);
        checks++; if (dout_valid !== 1'b1) begin failures++; $display("FAIL simul_first_valid got=%b exp=1", dout_valid); end
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            sin = w[i];
            sin_valid = 1'b1;
            dout_ready = (i == 3);
            tick();
        end
        sin_valid = 1'b0;
        dout_ready = 1'b0;
        checks++; if (dout !== 4'h2)       begin failures++; $display("FAIL simul_dout got=%h exp=2", dout); end
        checks++; if (dout_valid !== 1'b1) begin failures++; $display("FAIL simul_valid got=%b exp=1", dout_valid); end
        checks++; if (overrun !== 1'b0)    begin failures++; $display("FAIL simul_overrun got=%b exp=0", overrun); end
        dout_ready = 1'b1;
        tick();
        dout_ready = 1'b0;
    endtask

    task automatic test_restart();
        logic [3:0] w;
        w = 4'h8;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (2) begin
            sin = 1'b1;
            sin_valid = 1'b1;
            tick();
        end
        sin_valid = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++; if (dout_valid !== 1'b0) begin failures++; $display("FAIL restart_no_word got=%b exp=0", dout_valid); end
        checks++; if (busy !== 1'b1)       begin failures++; $display("FAIL restart_busy got=%b exp=1", busy); end
        for (int i = 0; i < 4; i++) begin
            sin = w[i];
            sin_valid = 1'b1;
            tick();
            if (i < 3) begin
                checks++; if (dout_valid !== 1'b0) begin failures++; $display("FAIL restart_early bit=%0d got=%b exp=0", i, dout_valid); end
            end
        end
        sin_valid = 1'b0;
        checks++; if (dout !== 4'h8)       begin failures++; $display("FAIL restart_dout got=%h exp=8", dout); end
        checks++; if (dout_valid !== 1'b1) begin failures++; $display("FAIL restart_valid got=%b exp=1", dout_valid); end
        dout_ready = 1'b1;
        tick();
        dout_ready = 1'b0;
    endtask

    task automatic test_start_priority();
        logic [3:0] w;
        w = 4'h6;
        start = 1'b1;
        tick();
        start = 1'b0;
        sin = 1'b1;
        sin_valid = 1'b1;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            sin = w[i];
            sin_valid = 1'b1;
            tick();
            if (i < 3) begin
                checks++; if (dout_valid !== 1'b0) begin failures++; $display("FAIL prio_early bit=%0d got=%b exp=0", i, dout_valid); end
            end
        end
        sin_valid = 1'b0;
        checks++; if (dout !== 4'h6)       begin failures++; $display("FAIL prio_dout got=%h exp=6", dout); end
        checks++; if (dout_valid !== 1'b1) begin failures++; $display("FAIL prio_valid got=%b exp=1", dout_valid); end
        dout_ready = 1'b1;
        tick();
        dout_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        dout_ready = 1'b1;
        send_word(4'hA);
        checks++; if (dout !== 4'hA)       begin failures++; $display("FAIL b2b_first_dout got=%h exp=a", dout); end
        checks++; if (dout_valid !== 1'b1) begin failures++; $display("FAIL b2b_first_valid got=%b exp=1", dout_valid); end
        send_word(4'h3);
        checks++; if (dout !== 4'h3)       begin failures++; $display("FAIL b2b_second_dout got=%h exp=3", dout); end
        checks++; if (dout_valid !== 1'b1) begin failures++; $display("FAIL b2b_second_valid got=%b exp=1", dout_valid); end
        checks++; if (overrun !== 1'b0)    begin failures++; $display("FAIL b2b_overrun got=%b exp=0", overrun); end
        tick();
        dout_ready = 1'b0;
        checks++; if (dout_valid !== 1'b0) begin failures++; $display("FAIL b2b_drain got=%b exp=0", dout_valid); end
    endtask

    task automatic test_reset_midframe();
        dout_ready = 1'b0;
        send_word(4'hD);
        send_word(4'h2);
        checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL rstmid_pre_overrun got=%b exp=1", overrun); end
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (2) begin
            sin = 1'b1;
            sin_valid = 1'b1;
            tick();
        end
        rstn = 1'b0;
        #1;
        checks++; if (dout !== 4'h0)       begin failures++; $display("FAIL rstmid_dout got=%h exp=0", dout); end
        checks++; if (dout_valid !== 1'b0) begin failures++; $display("FAIL rstmid_valid got=%b exp=0", dout_valid); end
        checks++; if (busy !== 1'b0)       begin failures++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
        checks++; if (overrun !== 1'b0)    begin failures++; $display("FAIL rstmid_overrun got=%b exp=0", overrun); end
        #5;
        rstn = 1'b1;
        tick();
        repeat (5) begin
            sin = 1'b1;
            sin_valid = 1'b1;
            tick();
        end
        sin_valid = 1'b0;
        checks++; if (dout_valid !== 1'b0) begin failures++; $display("FAIL rstmid_no_word got=%b exp=0", dout_valid); end
        checks++; if (busy !== 1'b0)       begin failures++; $display("FAIL rstmid_idle_busy got=%b exp=0", busy); end
        checks++; if (dout !== 4'h0)       begin failures++; $display("FAIL rstmid_dout_after got=%h exp=0", dout); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_gaps();
        test_overrun();
        test_simul_accept();
        test_restart();
        test_start_priority();
        test_back_to_back();
        test_reset_midframe();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
